// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM states, opcode and
// constant instruction words, and the program-counter width.
package cpu_pkg;

  localparam int unsigned PC_W = 16;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_e;

  localparam logic [4:0]      OPC_STP  = 5'b11111;
  localparam logic [PC_W-1:0] NOP_WORD = 16'h0000;
  localparam logic [PC_W-1:0] STP_WORD = 16'hF800;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program-counter register: asynchronous reset to RESET_VAL. When enabled, a
// load takes priority over an increment; with the enable low the value holds.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            sload,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      if (sload) begin
        q <= load_val;
      end else if (inc) begin
        q <= q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC / instruction-fetch stage with BOOT, RUN and HALT states.
// Optional retired-cycle counter is built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 16'h0000,
  parameter int unsigned     BOOT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            cnt_en,
  input  logic            pc_sload,
  input  logic [PC_W-1:0] new_pc,
  input  logic [PC_W-1:0] dec_addr1,
  input  logic [PC_W-1:0] dec_addr2,
  input  logic [PC_W-1:0] mem_q1,
  input  logic [PC_W-1:0] mem_q2,
  output logic [PC_W-1:0] mem_addr1,
  output logic [PC_W-1:0] mem_addr2,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] n_word,
  output logic            halted,
  output logic [31:0]     instr_count
);

  localparam logic [PC_W-1:0] RESET_PC_NEXT = RESET_PC + 1'b1;
  localparam logic [1:0]      BOOT_LAST     = 2'(BOOT_CYCLES - 1);

  fetch_state_e    state, state_next;
  logic [1:0]      boot_cnt;
  logic [PC_W-1:0] last_addr1, last_addr2;
  logic            boot_done;
  logic            run_go;
  logic            pc_en, pc_ld;
  logic [PC_W-1:0] pc_ld_val;

  assign boot_done = (state == BOOT) && (boot_cnt == BOOT_LAST);
  assign run_go    = (state == RUN) && !stall;

  always_comb begin
    state_next = state;
    mem_addr1  = last_addr1;
    mem_addr2  = last_addr2;
    instr      = mem_q1;
    n_word     = mem_q2;
    unique case (state)
      BOOT: begin
        mem_addr1 = RESET_PC;
        mem_addr2 = RESET_PC_NEXT;
        instr     = NOP_WORD;
        n_word    = NOP_WORD;
        if (boot_done) state_next = RUN;
      end
      RUN: begin
        if (!stall) begin
          mem_addr1 = dec_addr1;
          mem_addr2 = dec_addr2;
          if (mem_q1[15:11] == OPC_STP && !cnt_en && !pc_sload) state_next = HALT;
        end
      end
      HALT: begin
        instr  = STP_WORD;
        n_word = NOP_WORD;
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      boot_cnt   <= '0;
      last_addr1 <= RESET_PC;
      last_addr2 <= RESET_PC_NEXT;
      halted     <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state_next == HALT);
      if (state == BOOT) boot_cnt <= boot_cnt + 1'b1;
      if (run_go) begin
        last_addr1 <= dec_addr1;
        last_addr2 <= dec_addr2;
      end
    end
  end

  // Leaving BOOT reuses the load path to step the PC past the first word.
  assign pc_en     = boot_done || run_go;
  assign pc_ld     = (state == BOOT) || pc_sload;
  assign pc_ld_val = (state == BOOT) ? RESET_PC_NEXT : new_pc;

  pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .en      (pc_en),
    .sload   (pc_ld),
    .inc     (cnt_en),
    .load_val(pc_ld_val),
    .q       (pc)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
    end else if (run_go && instr_count != '1) begin
      instr_count <= instr_count + 1'b1;
    end
  end
`else
  assign instr_count = '0;
`endif

endmodule
